// File: rtl/pir_alert_sequencer.sv
// pir_alert_sequencer: qualifies PIR motion and sequences frame-locked alert colours onto the VGA pixel path
module pir_alert_sequencer #(
  parameter int WARMUP_FRAMES = 120,
  parameter int QUAL_CYCLES   = 1024,
  parameter int HOLD_FRAMES   = 180,
  parameter int BLINK_FRAMES  = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Motion_detected,
  input  logic       frame_start,
  input  logic       display_on,
  output logic [1:0] state,
  output logic       alert_active,
  output logic [3:0] vgaRed,
  output logic [3:0] vgaGreen,
  output logic [3:0] vgaBlue
);
  localparam logic [1:0] WARMUP = 2'd0;
  localparam logic [1:0] IDLE   = 2'd1;
  localparam logic [1:0] ALERT  = 2'd2;
  localparam logic [1:0] HOLD   = 2'd3;
  localparam int WW = $clog2(WARMUP_FRAMES + 1);
  localparam int QW = $clog2(QUAL_CYCLES + 1);
  localparam int HW = $clog2(HOLD_FRAMES + 1);
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  localparam logic [WW-1:0] WARM_LAST  = WW'(WARMUP_FRAMES - 1);
  localparam logic [QW-1:0] QUAL_FULL  = QW'(QUAL_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_FRAMES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
  logic [1:0]    sync_q;
  logic [QW-1:0] qual_cnt;
  logic          qualified;
  logic          motion_seen;
  logic [WW-1:0] warm_cnt, warm_nxt;
  logic [HW-1:0] hold_cnt, hold_nxt;
  logic [BW-1:0] blink_cnt, blink_nxt;
  logic          phase, phase_nxt;
  logic [1:0]    state_nxt;
  logic [11:0]   rgb_nxt;
  assign qualified = (qual_cnt == QUAL_FULL);
  // two-flop synchroniser, then a saturating run-length qualifier that any low sample clears
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync_q   <= '0;
      qual_cnt <= '0;
    end else begin
      sync_q   <= {sync_q[0], Motion_detected};
      qual_cnt <= !sync_q[1] ? '0 : qualified ? qual_cnt : qual_cnt + QW'(1);
    end
  // sticky motion flag; a qualification on the frame_start clock survives the clear
  always_ff @(posedge clk or posedge rst)
    if (rst) motion_seen <= 1'b0;
    else     motion_seen <= qualified | (motion_seen & ~frame_start);
  // frame-locked next-state logic; only frame_start clocks advance anything
  always_comb begin
    state_nxt = state;
    warm_nxt  = warm_cnt;
    hold_nxt  = hold_cnt;
    blink_nxt = blink_cnt;
    phase_nxt = phase;
    if (frame_start)
      case (state)
        WARMUP: if (warm_cnt == WARM_LAST) state_nxt = IDLE;
                else warm_nxt = warm_cnt + WW'(1);
        IDLE: if (motion_seen) begin
                state_nxt = ALERT;
                blink_nxt = '0;
                phase_nxt = 1'b1;
              end
        ALERT: if (!motion_seen) begin
                 state_nxt = HOLD;
                 hold_nxt  = '0;
               end else begin
                 blink_nxt = (blink_cnt == BLINK_LAST) ? '0 : blink_cnt + BW'(1);
                 phase_nxt = (blink_cnt == BLINK_LAST) ? ~phase : phase;
               end
        HOLD: if (motion_seen) begin
                state_nxt = ALERT;
                blink_nxt = '0;
                phase_nxt = 1'b1;
              end else if (hold_cnt == HOLD_LAST) state_nxt = IDLE;
              else hold_nxt = hold_cnt + HW'(1);
      endcase
  end
  // FSM state, counters and the alert flag registered together so they share timing
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state        <= WARMUP;
      alert_active <= 1'b0;
      warm_cnt     <= '0;
      hold_cnt     <= '0;
      blink_cnt    <= '0;
      phase        <= 1'b1;
    end else begin
      state        <= state_nxt;
      alert_active <= state_nxt[1];
      warm_cnt     <= warm_nxt;
      hold_cnt     <= hold_nxt;
      blink_cnt    <= blink_nxt;
      phase        <= phase;
      phase        <= phase_nxt;
    end
  // colour chosen from the current state; blanked outside active video
  always_comb
    rgb_nxt = !display_on    ? 12'h000 :
              state == WARMUP ? 12'h008 :
              state == IDLE   ? 12'h0F0 :
              state == ALERT  ? (phase ? 12'hF00 : 12'h000) :
                                12'hF80;
  // one-clock registered pixel stage; sync outputs are delayed externally to match
  always_ff @(posedge clk or posedge rst)
    if (rst) {vgaRed, vgaGreen, vgaBlue} <= '0;
    else     {vgaRed, vgaGreen, vgaBlue} <= rgb_nxt;
endmodule

// File: tb/tb_pir_alert_sequencer.sv
// tb_pir_alert_sequencer: scoreboard bench for frame-locked PIR alert sequencing
module tb_pir_alert_sequencer;
  logic       clk, rst, Motion_detected, frame_start, display_on;
  logic [1:0] state;
  logic       alert_active;
  logic [3:0] vgaRed, vgaGreen, vgaBlue;
  int         pix;
  int         tests, fails;
  typedef struct {
    string      name;
    logic [14:0] exp;
  } item_t;
  item_t sb[$];
  item_t it;
  event  chk_ev;
  pir_alert_sequencer #(
    .WARMUP_FRAMES(4),
    .QUAL_CYCLES(8),
    .HOLD_FRAMES(3),
    .BLINK_FRAMES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .Motion_detected(Motion_detected),
    .frame_start(frame_start),
    .display_on(display_on),
    .state(state),
    .alert_active(alert_active),
    .vgaRed(vgaRed),
    .vgaGreen(vgaGreen),
    .vgaBlue(vgaBlue)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  initial begin
    pix = 0;
    frame_start = 0;
    display_on = 0;
    forever begin
      @(posedge clk);
      #1;
      pix = (pix == 99) ? 0 : pix + 1;
      frame_start = (pix == 0);
      display_on = (pix >= 10 && pix <= 89);
    end
  end
  initial begin
    tests = 0;
    fails = 0;
    forever begin
      @(negedge clk or chk_ev);
      while (sb.size() > 0) begin
        it = sb.pop_front();
        tests++;
        if ({state, alert_active, vgaRed, vgaGreen, vgaBlue} !== it.exp) begin
          fails++;
          $display("FAIL %s: got state=%0d alert=%0b rgb=%h%h%h, expected state=%0d alert=%0b rgb=%h",
                   it.name, state, alert_active, vgaRed, vgaGreen, vgaBlue,
                   it.exp[14:13], it.exp[12], it.exp[11:0]);
        end
      end
    end
  end
  task automatic at_pix(input int p);
    do begin
      @(posedge clk);
      #2;
    end while (pix != p);
  endtask
  task automatic pulse(input int n);
    Motion_detected = 1;
    repeat (n) begin
      @(posedge clk);
      #2;
    end
    Motion_detected = 0;
  endtask
  task automatic chk(input string n, input logic [1:0] s, input logic a, input logic [11:0] rgb);
    item_t e;
    e.name = n;
    e.exp = {s, a, rgb};
    sb.push_back(e);
  endtask
  initial begin
    rst = 1;
    Motion_detected = 1;
    at_pix(5);  chk("reset", 0, 0, 12'h000);
    at_pix(50); rst = 0;
    at_pix(60); chk("warm_f0", 0, 0, 12'h008);
    for (int i = 1; i <= 3; i++) begin
      at_pix(50); chk("warm_hold", 0, 0, 12'h008);
    end
    at_pix(50); chk("warm_to_idle", 1, 0, 12'h0F0);
    at_pix(50); chk("idle_to_alert", 2, 1, 12'hF00);
    Motion_detected = 0;
    at_pix(50); chk("alert_stay", 2, 1, 12'hF00);
    at_pix(50); chk("hold_h0", 3, 1, 12'hF80);
    at_pix(50); chk("hold_h1", 3, 1, 12'hF80);
    at_pix(50); chk("hold_h2", 3, 1, 12'hF80);
    at_pix(50); chk("hold_to_idle", 1, 0, 12'h0F0);
    at_pix(20); pulse(7);
    at_pix(60); chk("pulse7_same", 1, 0, 12'h0F0);
    at_pix(90); chk("de_last", 1, 0, 12'h0F0);
    at_pix(91); chk("de_off", 1, 0, 12'h000);
    at_pix(10); chk("de_pre", 1, 0, 12'h000);
    at_pix(11); chk("pulse7_ignored", 1, 0, 12'h0F0);
    at_pix(20); pulse(8);
    at_pix(60); chk("pulse8_wait_fs", 1, 0, 12'h0F0);
    at_pix(70); Motion_detected = 1;
    at_pix(50); chk("blink_f1", 2, 1, 12'hF00);
    at_pix(50); chk("blink_f2", 2, 1, 12'hF00);
    at_pix(50); chk("blink_f3", 2, 1, 12'h000);
    at_pix(50); chk("blink_f4", 2, 1, 12'h000);
    at_pix(50); chk("blink_f5", 2, 1, 12'hF00);
    at_pix(50); chk("blink_f6", 2, 1, 12'hF00);
    at_pix(50); chk("blink_f7", 2, 1, 12'h000);
    Motion_detected = 0;
    at_pix(50); chk("alert_off_stay", 2, 1, 12'h000);
    at_pix(50); chk("hold_from_off", 3, 1, 12'hF80);
    at_pix(20); pulse(8);
    at_pix(50); chk("hold_second", 3, 1, 12'hF80);
    at_pix(50); chk("rearm_phase_on", 2, 1, 12'hF00);
    at_pix(50); chk("hold2_h0", 3, 1, 12'hF80);
    at_pix(50); chk("hold2_h1", 3, 1, 12'hF80);
    at_pix(50); chk("hold2_h2", 3, 1, 12'hF80);
    at_pix(50); chk("hold2_idle", 1, 0, 12'h0F0);
    at_pix(90); pulse(8);
    at_pix(50); chk("qual_on_fs_idle", 1, 0, 12'h0F0);
    at_pix(50); chk("qual_on_fs_alert", 2, 1, 12'hF00);
    at_pix(60);
    rst = 1;
    #1;
    chk("async_rst", 0, 0, 12'h000);
    ->chk_ev;
    @(posedge clk);
    #2;
    rst = 0;
    at_pix(70); chk("post_rst_warm", 0, 0, 12'h008);
    at_pix(50); chk("rewarm_w1", 0, 0, 12'h008);
    at_pix(50); chk("rewarm_w2", 0, 0, 12'h008);
    at_pix(50); chk("rewarm_w3", 0, 0, 12'h008);
    at_pix(50); chk("rewarm_idle", 1, 0, 12'h0F0);
    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard_drain: %0d pending, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
